rst_seq_clken_gen: RTL



---
 rtl/rst_seq_clken_gen.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/rst_seq_clken_gen.sv
// Reset sequencer: synchronised reset release, staggered per-channel reset deassertion, soft re-sequence and per-channel clock-enable dividers.
// Optional watchdog-triggered soft reset enabled by defining RST_SEQ_WDOG_EN.
`timescale 1ns/1ps
module rst_seq_clken_gen #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STAGE_DLY   = 16,
    parameter int HOLD_CYC    = 8,
    parameter int DIV_W       = 8,
    parameter int DEF_DIV     = 0
`ifdef RST_SEQ_WDOG_EN
    ,
    parameter int WDOG_CYC    = 1024
`endif
) (
    input  logic                    Clk,
    input  logic                    nReset,
    input  logic                    soft_rst_req,
    input  logic [N_CH*DIV_W-1:0]   div_ratio,
    input  logic                    div_load,
    output logic [N_CH-1:0]         ch_nrst,
    output logic [N_CH-1:0]         ch_ce,
    output logic                    seq_done,
    output logic [1:0]              seq_state
`ifdef RST_SEQ_WDOG_EN
    ,
    input  logic                    wdog_kick,
    output logic                    wdog_fired
`endif
);

    localparam int STG_W = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
    localparam int HLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int IDX_W = $clog2(N_CH + 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGE_DLY - 1);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_DONE = IDX_W'(N_CH);
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEF_DIV);

    typedef enum logic [2:0] {
        ST_ASSERT  = 3'd0,
        ST_SYNC    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_SOFT    = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rst_sync_s;
    logic [STG_W-1:0]       stg_r;
    logic [STG_W-1:0]       stg_nxt_s;
    logic [IDX_W-1:0]       idx_r;
    logic [IDX_W-1:0]       idx_nxt_s;
    logic [HLD_W-1:0]       hold_r;
    logic [HLD_W-1:0]       hold_nxt_s;
    logic [N_CH-1:0]        nrst_r;
    logic [N_CH-1:0]        nrst_nxt_s;
    logic [N_CH-1:0]        ce_r;
    logic [N_CH-1:0]        ce_nxt_s;
    logic [DIV_W-1:0]       ratio_r   [N_CH];
    logic [DIV_W-1:0]       cnt_r     [N_CH];
    logic [DIV_W-1:0]       cnt_nxt_s [N_CH];
    logic                   step_s;
    logic                   wdog_trip_s;
    logic                   done_r;
    logic                   done_nxt_s;
    logic [1:0]             state_out_r;
    logic [1:0]             state_out_nxt_s;

    assign rst_sync_s = sync_r[SYNC_STAGES-1];
    // The SYNC cycle that first sees rst_sync already counts as the first stagger cycle.
    assign step_s = ((state_r == ST_RELEASE) || ((state_r == ST_SYNC) && rst_sync_s))
                    && (idx_r != IDX_DONE);

`ifdef RST_SEQ_WDOG_EN
    localparam int WD_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);
    logic [WD_W-1:0] wdog_r;
    logic            wdog_fired_r;

    assign wdog_trip_s = (state_r == ST_RUN) && !wdog_kick && (wdog_r == WD_LAST);
    assign wdog_fired  = wdog_fired_r;

    // Watchdog counter runs only in RUN; the trip pulse is registered alongside SOFT entry.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            wdog_r       <= {WD_W{1'b0}};
            wdog_fired_r <= 1'b0;
        end else begin
            wdog_fired_r <= wdog_trip_s;
            if ((state_r != ST_RUN) || wdog_kick || wdog_trip_s) begin
                wdog_r <= {WD_W{1'b0}};
            end else begin
                wdog_r <= wdog_r + WD_W'(1);
            end
        end
    end
`else
    assign wdog_trip_s = 1'b0;
`endif

    // Reset-release synchroniser.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_r <= ST_ASSERT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ASSERT:  state_nxt_s = ST_SYNC;
            ST_SYNC:    state_nxt_s = rst_sync_s ? ST_RELEASE : ST_SYNC;
            ST_RELEASE: state_nxt_s = (idx_r == IDX_DONE) ? ST_RUN : ST_RELEASE;
            ST_RUN:     state_nxt_s = (soft_rst_req || wdog_trip_s) ? ST_SOFT : ST_RUN;
            ST_SOFT:    state_nxt_s = (hold_r == HLD_LAST) ? ST_RELEASE : ST_SOFT;
            default:    state_nxt_s = ST_ASSERT;
        endcase
    end

    // FSM output decode, taken from the next state so the registered outputs track state_r.
    always_comb begin
        done_nxt_s      = 1'b0;
        state_out_nxt_s = 2'd0;
        case (state_nxt_s)
            ST_ASSERT:  state_out_nxt_s = 2'd0;
            ST_SYNC:    state_out_nxt_s = 2'd1;
            ST_RELEASE: state_out_nxt_s = 2'd2;
            ST_RUN: begin
                state_out_nxt_s = 2'd3;
                done_nxt_s      = 1'b1;
            end
            ST_SOFT:    state_out_nxt_s = 2'd3;
            default:    state_out_nxt_s = 2'd0;
        endcase
    end

    // Stagger counter, channel index, soft-hold counter and channel reset next values.
    always_comb begin
        stg_nxt_s  = stg_r;
        idx_nxt_s  = idx_r;
        hold_nxt_s = hold_r;
        nrst_nxt_s = nrst_r;
        if ((state_r == ST_RUN) && (state_nxt_s == ST_SOFT)) begin
            nrst_nxt_s = {N_CH{1'b0}};
            hold_nxt_s = {HLD_W{1'b0}};
            stg_nxt_s  = {STG_W{1'b0}};
            idx_nxt_s  = {IDX_W{1'b0}};
        end else if (state_r == ST_SOFT) begin
            hold_nxt_s = hold_r + HLD_W'(1);
            stg_nxt_s  = {STG_W{1'b0}};
            idx_nxt_s  = {IDX_W{1'b0}};
        end else if (step_s && (stg_r == STG_LAST)) begin
            stg_nxt_s = {STG_W{1'b0}};
            idx_nxt_s = idx_r + IDX_W'(1);
            for (int k = 0; k < N_CH; k++) begin
                nrst_nxt_s[k] = nrst_r[k] | (idx_r == IDX_W'(k));
            end
        end else if (step_s) begin
            stg_nxt_s = stg_r + STG_W'(1);
        end else begin
            stg_nxt_s = stg_r;
        end
    end

    // Per-channel divider: a load or a channel going into reset restarts the period from zero.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            cnt_nxt_s[k] = cnt_r[k];
            ce_nxt_s[k]  = nrst_r[k] & nrst_nxt_s[k] & ~div_load & (cnt_r[k] == ratio_r[k]);
            if (!nrst_r[k] || !nrst_nxt_s[k] || div_load) begin
                cnt_nxt_s[k] = {DIV_W{1'b0}};
            end else if (cnt_r[k] == ratio_r[k]) begin
                cnt_nxt_s[k] = {DIV_W{1'b0}};
            end else begin
                cnt_nxt_s[k] = cnt_r[k] + DIV_W'(1);
            end
        end
    end

    // Sequencer, divider and output registers.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            stg_r       <= {STG_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            hold_r      <= {HLD_W{1'b0}};
            nrst_r      <= {N_CH{1'b0}};
            ce_r        <= {N_CH{1'b0}};
            done_r      <= 1'b0;
            state_out_r <= 2'd0;
            for (int k = 0; k < N_CH; k++) begin
                ratio_r[k] <= DIV_RST;
                cnt_r[k]   <= {DIV_W{1'b0}};
            end
        end else begin
            stg_r       <= stg_nxt_s;
            idx_r       <= idx_nxt_s;
            hold_r      <= hold_nxt_s;
            nrst_r      <= nrst_nxt_s;
            ce_r        <= ce_nxt_s;
            done_r      <= done_nxt_s;
            state_out_r <= state_out_nxt_s;
            for (int k = 0; k < N_CH; k++) begin
                cnt_r[k] <= cnt_nxt_s[k];
                if (div_load) begin
                    ratio_r[k] <= div_ratio[k*DIV_W +: DIV_W];
                end else begin
                    ratio_r[k] <= ratio_r[k];
                end
            end
        end
    end

    assign ch_nrst   = nrst_r;
    assign ch_ce     = ce_r;
    assign seq_done  = done_r;
    assign seq_state = state_out_r;

endmodule
